// File: rtl/seq_multiplier_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier_if
//  Description : Operand / result bundle between execute-stage control and
//                the sequential unsigned multiplier.
//                  operation : 6-bit operation code (MULTU launches)
//                  dataA     : multiplicand
//                  dataB     : multiplier
//                  busy      : multiply in progress
//                  done      : one-cycle pulse, product valid from here on
//                  prodHi    : upper half of the product
//                  prodLo    : lower half of the product
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_multiplier_if #(
    parameter int WIDTH = 32
) ();
    logic [5:0]       operation;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] prodHi;
    logic [WIDTH-1:0] prodLo;

    modport master (
        output operation, dataA, dataB,
        input  busy, done, prodHi, prodLo
    );

    modport slave (
        input  operation, dataA, dataB,
        output busy, done, prodHi, prodLo
    );
endinterface
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier
//  Description : Sequential WIDTH x WIDTH -> 2*WIDTH unsigned shift-add
//                multiplier. Retires one multiplier bit per clock, so a
//                launch yields a done pulse WIDTH+1 cycles later.
//  Ports       : clk   - rising-edge clock
//                reset - synchronous active-high reset
//                bus   - seq_multiplier_if.slave (operands, status, product)
//  Revision    : 1.0  initial release
// ============================================================================
module seq_multiplier #(
    parameter int          WIDTH = 32,
    parameter logic [5:0]  MULTU = 6'b011001
) (
    input  wire logic          clk,
    input  wire logic          reset,
    seq_multiplier_if.slave    bus
);

    localparam int                 C_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);
    localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     w_mcand_nxt;
    // Bit 2*WIDTH holds the adder carry so an all-ones product is not lost.
    logic [2*WIDTH:0]     r_prod;
    logic [2*WIDTH:0]     w_prod_nxt;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [C_CNT_W-1:0]   w_cnt_nxt;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_upper;
    logic                 w_launch;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mcand <= w_mcand_nxt;
            r_prod  <= w_prod_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mcand_nxt = r_mcand;
        w_prod_nxt  = r_prod;
        w_cnt_nxt   = r_cnt;

        w_launch = (bus.operation == MULTU);
        // WIDTH+1-bit add keeps the carry out of the upper half.
        w_sum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        w_upper  = r_prod[0] ? w_sum : r_prod[2*WIDTH:WIDTH];

        case (r_state)
            S_IDLE, S_DONE: begin
                // DONE accepts a launch exactly like IDLE, giving back-to-back
                // multiplies with no idle gap.
                if (w_launch) begin
                    w_mcand_nxt = bus.dataA;
                    w_prod_nxt  = {1'b0, {WIDTH{1'b0}}, bus.dataB};
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                // Conditional add into the upper half, then shift the whole
                // register right with zero entering the MSB.
                w_prod_nxt = {1'b0, w_upper, r_prod[WIDTH-1:1]};
                w_cnt_nxt  = r_cnt + C_ONE;
                if (r_cnt == C_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.busy   = (r_state == S_RUN);
    assign bus.done   = (r_state == S_DONE);
    assign bus.prodHi = r_prod[2*WIDTH-1:WIDTH];
    assign bus.prodLo = r_prod[WIDTH-1:0];

endmodule
`default_nettype wire
